// File: rtl/mux_seq_nw.sv
// -----------------------------------------------------------------------------
// mux_seq_nw
// Registered N-channel, W-bit data selector with an active-low strobe and an
// auto-scan mode that steps through the channels with a programmable dwell.
//
// Parameters:
//   WIDTH    - bits per channel
//   CHANNELS - number of input channels (>= 2)
//   SELW     - select width (CHANNELS <= 2**SELW)
//   DWELL    - cycles spent on each channel in scan mode (>= 1)
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   din      - packed channel inputs, channel k = din[k*WIDTH +: WIDTH]
//   sel      - channel select (direct mode) / start channel (scan entry)
//   enb_n    - active-low strobe
//   mode     - 0 = direct, 1 = scan
//   y        - registered selected data
//   y_valid  - y holds real channel data
//   y_chan   - channel that produced y
//   wrap     - one-cycle pulse on the first output of channel 0 after a
//              scan wrap from the last channel
//
// Build option:
//   MUX_HOLD_EN - when defined, y holds its last value while enb_n = 1;
//                 otherwise y is driven to 0 while not strobed.
// -----------------------------------------------------------------------------
module mux_seq_nw #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int SELW     = 1,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      enb_n,
  input  logic                      mode,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SELW-1:0]           y_chan,
  output logic                      wrap
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   CH_N    = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);
  localparam logic [DW-1:0]   DW_LAST = DW'(DWELL - 1);

  typedef enum logic {S_DIRECT = 1'b0, S_SCAN = 1'b1} state_t;

  state_t          state;
  logic [SELW-1:0] ch;
  logic [DW-1:0]   dwell_cnt;
  // Set when the scan has just advanced from the last channel to 0, so the
  // wrap pulse lines up with the first output of channel 0, not the last
  // output of the final channel.
  logic            wrap_pend;

  logic            entry;
  logic            in_range;
  logic [SELW-1:0] scan_ch;
  logic [DW-1:0]   scan_dw;
  logic [SELW-1:0] pick_ch;
  logic [WIDTH-1:0] pick_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    entry     = (state == S_DIRECT) && mode;
    in_range  = {1'b0, sel} < CH_N;
    // On the entry edge the output already comes from the freshly loaded
    // channel, and that edge counts as the first dwell cycle.
    scan_ch   = entry ? (in_range ? sel : '0) : ch;
    scan_dw   = entry ? '0 : dwell_cnt;
    pick_ch   = mode ? scan_ch : sel;
    pick_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick_ch == SELW'(k)) pick_data = din[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_DIRECT;
      ch        <= '0;
      dwell_cnt <= '0;
      wrap_pend <= 1'b0;
      y         <= '0;
      y_valid   <= 1'b0;
      y_chan    <= '0;
      wrap      <= 1'b0;
    end else begin
      state <= mode ? S_SCAN : S_DIRECT;

      // Entry load happens even when not strobed.
      if (entry) begin
        ch        <= scan_ch;
        dwell_cnt <= '0;
        wrap_pend <= 1'b0;
      end
      if (!mode) wrap_pend <= 1'b0;

      if (enb_n) begin
        // Counters freeze, y_chan holds.
        y_valid <= 1'b0;
        wrap    <= 1'b0;
`ifdef MUX_HOLD_EN
        y <= y;
`else
        y <= '0;
`endif
      end else if (mode) begin
        y       <= pick_data;
        y_chan  <= scan_ch;
        y_valid <= 1'b1;
        wrap    <= wrap_pend;
        if (scan_dw == DW_LAST) begin
          dwell_cnt <= '0;
          if (scan_ch == CH_LAST) begin
            ch        <= '0;
            wrap_pend <= 1'b1;
          end else begin
            ch        <= scan_ch + 1'b1;
            wrap_pend <= 1'b0;
          end
        end else begin
          dwell_cnt <= scan_dw + 1'b1;
          ch        <= scan_ch;
          wrap_pend <= 1'b0;
        end
      end else begin
        y       <= in_range ? pick_data : '0;
        y_valid <= in_range;
        y_chan  <= sel;
        wrap    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_seq_nw.sv
// -----------------------------------------------------------------------------
// tb_mux_seq_nw
// Directed bench for mux_seq_nw with WIDTH=4, CHANNELS=3, SELW=2, DWELL=2.
// Channel data: ch0=5, ch1=A, ch2=3. The stimulus process drives one vector
// per cycle and queues the hand-computed response; a monitor process pops
// and compares just after each rising edge.
// -----------------------------------------------------------------------------
module tb_mux_seq_nw;

`ifdef MUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din;
  logic [1:0]  sel;
  logic        enb_n;
  logic        mode;
  logic [3:0]  y;
  logic        y_valid;
  logic [1:0]  y_chan;
  logic        wrap;

  mux_seq_nw #(.WIDTH(4), .CHANNELS(3), .SELW(2), .DWELL(2)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .enb_n(enb_n),
    .mode(mode), .y(y), .y_valid(y_valid), .y_chan(y_chan), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] y;
    logic       v;
    logic [1:0] ch;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the output registered at each edge against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".y"},       {4'h0, y},       {4'h0, e.y});
        check({e.name, ".y_valid"}, {7'h0, y_valid}, {7'h0, e.v});
        check({e.name, ".y_chan"},  {6'h0, y_chan},  {6'h0, e.ch});
        check({e.name, ".wrap"},    {7'h0, wrap},    {7'h0, e.w});
      end
    end
  end

  task automatic drive(input string name, input logic r, input logic [1:0] s,
                       input logic en, input logic m, input logic [3:0] ey,
                       input logic ev, input logic [1:0] ech, input logic ew);
    exp_t e;
    @(negedge clk);
    reset = r; sel = s; enb_n = en; mode = m;
    e.name = name; e.y = ey; e.v = ev; e.ch = ech; e.w = ew;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; enb_n = 1'b1; mode = 1'b0;
    din   = 12'h3A5;

    //     name          r  sel  en m   y                    v  ch  w
    drive("reset",      1, 2'd0, 1, 0, 4'h0,                0, 2'd0, 0);
    drive("dir_sel0",   0, 2'd0, 0, 0, 4'h5,                1, 2'd0, 0);
    drive("dir_sel1",   0, 2'd1, 0, 0, 4'hA,                1, 2'd1, 0);
    drive("dir_sel0b",  0, 2'd0, 0, 0, 4'h5,                1, 2'd0, 0);
    drive("strobe_off", 0, 2'd0, 1, 0, HOLD ? 4'h5 : 4'h0,  0, 2'd0, 0);
    drive("dir_sel2",   0, 2'd2, 0, 0, 4'h3,                1, 2'd2, 0);
    drive("dir_oor",    0, 2'd3, 0, 0, 4'h0,                0, 2'd3, 0);
    drive("oor_off",    0, 2'd3, 1, 0, 4'h0,                0, 2'd3, 0);
    // Scan from channel 1: 1,1,2,2,0(wrap),0,1,1,2
    drive("scan_entry", 0, 2'd1, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("scan_1b",    0, 2'd0, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("scan_2a",    0, 2'd3, 0, 1, 4'h3,                1, 2'd2, 0);
    drive("scan_2b",    0, 2'd0, 0, 1, 4'h3,                1, 2'd2, 0);
    drive("scan_wrap",  0, 2'd0, 0, 1, 4'h5,                1, 2'd0, 1);
    drive("scan_0b",    0, 2'd0, 0, 1, 4'h5,                1, 2'd0, 0);
    drive("scan_1c",    0, 2'd0, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("scan_1d",    0, 2'd0, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("scan_2c",    0, 2'd0, 0, 1, 4'h3,                1, 2'd2, 0);
    // Freeze for 3 cycles after the first dwell cycle on channel 2
    drive("freeze1",    0, 2'd0, 1, 1, HOLD ? 4'h3 : 4'h0,  0, 2'd2, 0);
    drive("freeze2",    0, 2'd0, 1, 1, HOLD ? 4'h3 : 4'h0,  0, 2'd2, 0);
    drive("freeze3",    0, 2'd0, 1, 1, HOLD ? 4'h3 : 4'h0,  0, 2'd2, 0);
    drive("resume_2",   0, 2'd0, 0, 1, 4'h3,                1, 2'd2, 0);
    drive("resume_wr",  0, 2'd0, 0, 1, 4'h5,                1, 2'd0, 1);
    drive("resume_0b",  0, 2'd0, 0, 1, 4'h5,                1, 2'd0, 0);
    drive("resume_1a",  0, 2'd0, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("resume_1b",  0, 2'd0, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("resume_2a",  0, 2'd1, 0, 1, 4'h3,                1, 2'd2, 0);
    // Reset mid-scan, then fresh entry from sel
    drive("mid_reset",  1, 2'd1, 0, 1, 4'h0,                0, 2'd0, 0);
    drive("reentry",    0, 2'd1, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("reentry_b",  0, 2'd1, 0, 1, 4'hA,                1, 2'd1, 0);
    drive("back_dir",   0, 2'd0, 0, 0, 4'h5,                1, 2'd0, 0);
    // Out-of-range scan entry starts at channel 0 without a wrap
    drive("oor_entry",  0, 2'd3, 0, 1, 4'h5,                1, 2'd0, 0);
    drive("oor_0b",     0, 2'd3, 0, 1, 4'h5,                1, 2'd0, 0);
    drive("oor_1a",     0, 2'd3, 0, 1, 4'hA,                1, 2'd1, 0);
    // Entry while not strobed still loads the start channel
    drive("dir_again",  0, 2'd0, 0, 0, 4'h5,                1, 2'd0, 0);
    drive("entry_off",  0, 2'd2, 1, 1, HOLD ? 4'h5 : 4'h0,  0, 2'd0, 0);
    drive("eoff_2a",    0, 2'd0, 0, 1, 4'h3,                1, 2'd2, 0);
    drive("eoff_2b",    0, 2'd0, 0, 1, 4'h3,                1, 2'd2, 0);
    drive("eoff_wrap",  0, 2'd0, 0, 1, 4'h5,                1, 2'd0, 1);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_seq_nw.md
# mux_seq_nw

Registered, parametrised N-channel, W-bit data selector with active-low strobe. It is the clocked successor to the quad 2-to-1 selector parts used for address and data steering in the processor model. It adds two things: an auto-scan mode that steps through the channels with a programmable dwell, and registered outputs that carry a valid flag, the selected channel number and a wrap pulse. It sits on the clock domain of the datapath it steers, for example multiplexed memory addressing or a bus time-slicer.

## Interface
- `WIDTH`, default 4: bits per channel.
- `CHANNELS`, default 2: number of input channels, at least 2.
- `SELW`, default 1: select width. Requires `CHANNELS <= 2**SELW`.
- `DWELL`, default 1: cycles spent on each channel in scan mode, at least 1.

- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `din`: input, `CHANNELS*WIDTH` bits. Packed channel inputs; channel k is `din[k*WIDTH +: WIDTH]`.
- `sel`: input, `SELW` bits. Channel select in direct mode; start channel on scan entry.
- `enb_n`: input, 1 bit. Active-low strobe.
- `mode`: input, 1 bit. 0 selects direct mode, 1 selects scan mode.
- `y`: output, `WIDTH` bits. Registered selected data.
- `y_valid`: output, 1 bit. `y` holds real channel data.
- `y_chan`: output, `SELW` bits. Channel that produced `y`.
- `wrap`: output, 1 bit. One-cycle pulse when scan wraps from the last channel to channel 0.

## Operation
- State machine has two states, S_DIRECT and S_SCAN.
  - S_DIRECT to S_SCAN when `mode`=1 is sampled.
  - S_SCAN to S_DIRECT when `mode`=0 is sampled.
  - The transition takes effect on the same edge that samples `mode`, so that edge's output already follows the new state's rules.
- Internal counters:
  - `ch` is `SELW` bits.
  - `dwell_cnt` counts 0 to `DWELL-1`.
- S_DIRECT, `enb_n`=0:
  - If `sel` < `CHANNELS`: `y` <= channel `sel`, `y_chan` <= `sel`, `y_valid` <= 1.
  - If `sel` >= `CHANNELS`: `y` <= 0, `y_valid` <= 0, `y_chan` <= `sel`.
- S_SCAN entry edge:
  - `ch` <= `sel` if `sel` is in range, else 0; `dwell_cnt` <= 0.
  - The output on that edge is taken from the new `ch`.
- S_SCAN, `enb_n`=0, each cycle:
  - `y` <= channel `ch`, `y_chan` <= `ch`, `y_valid` <= 1.
  - If `dwell_cnt` = `DWELL-1`: `dwell_cnt` <= 0 and `ch` advances.
  - When advancing from `CHANNELS-1`, `ch` <= 0 and `wrap` <= 1 for one cycle. Otherwise `ch` <= `ch`+1.
  - If `dwell_cnt` < `DWELL-1`: `dwell_cnt` increments.
- `enb_n`=1, either state:
  - `ch` and `dwell_cnt` freeze; `wrap` <= 0; `y_valid` <= 0.
  - `y` follows the Configuration section; `y_chan` holds.
- Simultaneous events:
  - A `mode` change while `enb_n`=1 still changes state, and the entry load of `ch` still occurs.
  - `wrap` can only pulse while `enb_n`=0.
- `sel` is ignored in S_SCAN except on the entry edge.

## Timing
- Every output is registered. Latency from `din`/`sel`/`enb_n` to `y` is exactly 1 cycle. No combinational path to outputs.
- Scan period is `CHANNELS*DWELL` cycles. `wrap` asserts in the cycle that `y_chan` first shows 0 after showing `CHANNELS-1`.
- Reset values, applied on the edge where `reset`=1 regardless of other inputs:
  - `y`=0, `y_valid`=0, `y_chan`=0, `wrap`=0.
  - State S_DIRECT, `ch`=0, `dwell_cnt`=0.
- Reset mid-scan discards position. The first post-reset edge with `mode`=1 performs a fresh scan entry from `sel`.

## Configuration
- `MUX_HOLD_EN`:
  - Defined: while `enb_n`=1, `y` holds its last value; `y_valid` still drops to 0.
  - Not defined: while `enb_n`=1, `y` <= 0. This is classic strobe behaviour, with all data bits low when not strobed.
  - All other behaviour is identical in both builds.

## Test plan
- Direct select, `WIDTH`=4, `CHANNELS`=2: `din`=8'hA5, `enb_n`=0.
  - `sel`=0: `y`=5, `y_chan`=0, `y_valid`=1, one cycle after the input is applied.
  - `sel`=1: `y`=A one cycle later.
- Strobe: with `enb_n`=1 after `y`=5, `y_valid`=0 next cycle.
  - Without `MUX_HOLD_EN`: `y`=0.
  - With `MUX_HOLD_EN`: `y`=5.
- Scan, `CHANNELS`=3, `SELW`=2, `DWELL`=2, `sel`=1, `mode` 0 to 1:
  - `y_chan` sequence is 1,1,2,2,0,0,1,…
  - `wrap`=1 only on the first cycle showing 0.
- Out of range, `CHANNELS`=3, `sel`=3:
  - Direct mode: `y`=0, `y_valid`=0.
  - Scan entry: scan starts at `ch`=0.
- Freeze: pulse `enb_n`=1 for 3 cycles mid-scan at `y_chan`=2 with first dwell cycle done. The scan resumes with one more cycle on channel 2, with no skipped channel.
- Reset mid-scan: assert `reset` for 1 cycle while `y_chan`=2. The next cycle shows all outputs 0 and state S_DIRECT; with `mode` still 1, the following edge re-enters scan at `sel`.
